spart_driver: RTL
=================

Name: spart_driver

Overview:
- Bus-master controller that sequences the spart block over its iocs/iorw/ioaddr/databus processor interface.
- After reset it programs the 16-bit baud divisor from a 2-bit baud select, then runs a receive-and-echo loop: wait for rda, read the receive buffer, wait for tbr, write the character back.
- It sits beside spart in the top level, standing in for the processor, and re-programs the divisor whenever the baud select changes.

Parameters:
- DIV_4800, 16'd1042, clocks per bit at 4800 baud.
- DIV_9600, 16'd521, clocks per bit at 9600 baud.
- DIV_19200, 16'd260, clocks per bit at 19200 baud.
- DIV_38400, 16'd130, clocks per bit at 38400 baud.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset; asynchronous, active-high (one clock domain only).
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400; asynchronous switch input.
- rda  in  1  spart read data available.
- tbr  in  1  spart transmit buffer ready.
- iocs  out  1  spart chip select.
- iorw  out  1  1=read, 0=write.
- ioaddr  out  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high.
- databus  inout  8  driven only while iocs=1 and iorw=0; high-Z otherwise.
- echo_cnt  out  8  count of characters echoed.

Behaviour:
- Outputs are Moore-decoded from the registered state; no output depends combinationally on rda or tbr.
- Reset values: state=CFG_LOW, iocs=0, iorw=1, ioaddr=00, databus=Z, char_reg=0, echo_cnt=0, cfg_reg=00, both sync flops=00.
- br_cfg passes through a 2-flop synchronizer to give br_sync. Every reference to br_cfg below means br_sync.
- CFG_LOW (1 cycle):
  - iocs=1, iorw=0, ioaddr=10, databus=div[7:0].
  - div is selected by br_sync; cfg_reg<=br_sync on this edge.
  - Next state: CFG_HIGH.
- CFG_HIGH (1 cycle):
  - iocs=1, iorw=0, ioaddr=11, databus=div[15:8].
  - div here is selected by cfg_reg, not br_sync, so the two bytes are always consistent.
  - Next state: WAIT_RX.
- WAIT_RX:
  - iocs=0, databus=Z.
  - If br_sync!=cfg_reg, go to CFG_LOW. This takes priority over rda; spart holds rda, so the character is still read after reconfiguring.
  - Else if rda=1, go to READ_RX.
  - Else stay in WAIT_RX.
- READ_RX (1 cycle):
  - iocs=1, iorw=1, ioaddr=00, databus=Z.
  - char_reg<=databus at the closing edge.
  - Next state: WAIT_TX.
- WAIT_TX:
  - iocs=0.
  - If tbr=1, go to WRITE_TX; else stay.
  - A br_cfg change is ignored here.
- WRITE_TX (1 cycle):
  - iocs=1, iorw=0, ioaddr=00, databus=char_reg.
  - echo_cnt<=echo_cnt+1; wraps 8'hFF->8'h00.
  - Next state: WAIT_RX.
- Reconfiguration occurs only from WAIT_RX, so an echo is never split by a divisor change.
- Minimum echo latency: rda sampled high in WAIT_RX at edge n gives READ_RX in cycle n+1, WAIT_TX in n+2, and WRITE_TX in n+3 when tbr is already 1.
- tbr or rda that are constantly high cause back-to-back echoes with no extra idle beyond WAIT_RX/WAIT_TX, each held for at least 1 cycle.
- rst asserted in any state:
  - Immediately releases databus and forces iocs=0.
  - After deassertion the sequence restarts at CFG_LOW.
  - Any partially handled character is dropped and echo_cnt is cleared.
- No bus contention: every state in which databus is driven has iorw=0.
- The status address (01) is never issued by this block; it is reserved for future polling.

Decomposition:
- Package spart_pkg holds:
  - drv_state_t enum: CFG_LOW, CFG_HIGH, WAIT_RX, READ_RX, WAIT_TX, WRITE_TX, 3-bit.
  - ioaddr constants: ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11.
  - Baud-select encodings.
- One sub-module, sync2: 2-bit, 2-flop synchronizer with async active-high reset to 0, instantiated for br_cfg.
- The divisor lookup is an inline case statement.

Test Plan:
- Reset release with br_cfg=01:
  - Within 2 sync cycles, CFG_LOW drives ioaddr=10 with databus=8'h09.
  - CFG_HIGH follows with ioaddr=11 and databus=8'h02 (521=0x0209).
  - Then iocs=0 and databus=Z.
- Echo path:
  - Stimulus: pulse rda with the spart model driving 8'h41 on the READ_RX cycle, and tbr=1.
  - Required: WRITE_TX drives databus=8'h41 with ioaddr=00 exactly 3 cycles after rda is sampled, and echo_cnt goes 0->1.
- tbr back-pressure:
  - Stimulus: hold tbr=0 for 50 cycles after a read.
  - Required: iocs stays 0 throughout; the write of the held character occurs in the cycle after tbr rises.
- Baud change:
  - br_cfg 01->11 while idle: the divisor is rewritten with 8'h82 then 8'h00.
  - The same change during WAIT_TX: the rewrite happens only after WRITE_TX completes.
- Simultaneous events:
  - br_cfg change and rda in the same WAIT_RX cycle: reconfiguration happens first, then READ_RX.
  - 256 echoes: echo_cnt wraps to 0.
- Reset mid-operation:
  - Stimulus: assert rst during WRITE_TX.
  - Required: databus goes Z and iocs=0 with no clock edge needed, echo_cnt=0, and the restart begins with CFG_LOW.

Source files
------------

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spart_pkg
//  Purpose  : Shared types and encodings for the spart bus-master driver:
//             driver state enum, spart ioaddr map and baud-select codes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LOW  = 3'd0,
    CFG_HIGH = 3'd1,
    WAIT_RX  = 3'd2,
    READ_RX  = 3'd3,
    WAIT_TX  = 3'd4,
    WRITE_TX = 3'd5
  } drv_state_t;

  // spart register map on ioaddr
  localparam logic [1:0] ADDR_BUF  = 2'b00;  // TX/RX buffer
  localparam logic [1:0] ADDR_STAT = 2'b01;  // status (reserved, never issued)
  localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low byte
  localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high byte

  // Baud-select switch encodings
  localparam logic [1:0] BR_4800  = 2'b00;
  localparam logic [1:0] BR_9600  = 2'b01;
  localparam logic [1:0] BR_19200 = 2'b10;
  localparam logic [1:0] BR_38400 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spart_driver_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : sync2
//  Purpose  : 2-bit, two-flop synchronizer for a slowly changing switch input.
//  Ports    : clk  - destination clock
//             rst  - asynchronous active-high reset, clears both stages
//             d_i  - asynchronous input
//             q_o  - synchronized output (two clocks of latency)
//  Revision : 1.0  initial release
// ============================================================================
module sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
//  Module   : spart_driver
//  Purpose  : Processor stand-in for spart. Programs the baud divisor from
//             the br_cfg switch, then echoes every received character back.
//             Re-programs the divisor whenever the switch changes while idle.
//  Ports    : clk, rst      - clock, async active-high reset
//             br_cfg[1:0]   - baud select switch (asynchronous)
//             rda, tbr      - spart receive-available / transmit-ready
//             iocs, iorw    - spart chip select, 1=read 0=write
//             ioaddr[1:0]   - spart register address
//             databus[7:0]  - bidirectional data, driven only on writes
//             echo_cnt[7:0] - number of characters echoed (wrapping)
//  Revision : 1.0  initial release
// ============================================================================
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = 16'd1042,
  parameter logic [15:0] DIV_9600  = 16'd521,
  parameter logic [15:0] DIV_19200 = 16'd260,
  parameter logic [15:0] DIV_38400 = 16'd130
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] echo_cnt
);

  drv_state_t state_q, state_d;
  logic [1:0] cfg_q, cfg_d;
  logic [7:0] char_q, char_d;
  logic [7:0] echo_q, echo_d;

  logic [1:0]  w_br_sync;
  logic [1:0]  w_div_sel;
  logic [15:0] w_div;
  logic        w_cs, w_rw, w_drive;
  logic [1:0]  w_addr;
  logic [7:0]  w_dout;

  sync2 u_sync_br (
    .clk (clk),
    .rst (rst),
    .d_i (br_cfg),
    .q_o (w_br_sync)
  );

  // The high byte uses the select latched with the low byte so a switch
  // change between the two writes can never produce a mixed divisor.
  always_comb begin
    w_div_sel = (state_q == CFG_HIGH) ? cfg_q : w_br_sync;
    case (w_div_sel)
      BR_4800:  w_div = DIV_4800;
      BR_9600:  w_div = DIV_9600;
      BR_19200: w_div = DIV_19200;
      default:  w_div = DIV_38400;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CFG_LOW;
      cfg_q   <= 2'b00;
      char_q  <= 8'h00;
      echo_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      char_q  <= char_d;
      echo_q  <= echo_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    char_d  = char_q;
    echo_d  = echo_q;
    w_cs    = 1'b0;
    w_rw    = 1'b1;
    w_addr  = ADDR_BUF;
    w_drive = 1'b0;
    w_dout  = 8'h00;
    case (state_q)
      CFG_LOW: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_addr  = ADDR_DBL;
        w_drive = 1'b1;
        w_dout  = w_div[7:0];
        cfg_d   = w_br_sync;
        state_d = CFG_HIGH;
      end
      CFG_HIGH: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_addr  = ADDR_DBH;
        w_drive = 1'b1;
        w_dout  = w_div[15:8];
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        // Reconfigure first; spart keeps rda high so nothing is lost.
        if (w_br_sync != cfg_q) state_d = CFG_LOW;
        else if (rda)           state_d = READ_RX;
      end
      READ_RX: begin
        w_cs    = 1'b1;
        w_rw    = 1'b1;
        w_addr  = ADDR_BUF;
        char_d  = databus;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tbr) state_d = WRITE_TX;
      end
      WRITE_TX: begin
        w_cs    = 1'b1;
        w_rw    = 1'b0;
        w_addr  = ADDR_BUF;
        w_drive = 1'b1;
        w_dout  = char_q;
        echo_d  = echo_q + 8'd1;
        state_d = WAIT_RX;
      end
      default: state_d = CFG_LOW;
    endcase
  end

  // Reset releases the bus immediately, without waiting for a clock edge,
  // even though the reset state itself is a driving state.
  assign iocs     = w_cs & ~rst;
  assign iorw     = w_rw | rst;
  assign ioaddr   = rst ? ADDR_BUF : w_addr;
  assign databus  = (w_drive && !rst) ? w_dout : 8'hzz;
  assign echo_cnt = echo_q;

endmodule
`default_nettype wire
